// File: rtl/sps_token_reorder_buffer_if.sv
// Token output handshake between the reorder buffer and the attention part.
interface sps_token_reorder_buffer_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  o_token_valid;
  logic [2*DATA_W-1:0]   o_token_data;
  logic                  o_token_last;
  logic                  i_token_ready;

  modport master (
    output o_token_valid,
    output o_token_data,
    output o_token_last,
    input  i_token_ready
  );

  modport slave (
    input  o_token_valid,
    input  o_token_data,
    input  o_token_last,
    output i_token_ready
  );
endinterface

// File: rtl/sps_token_reorder_buffer.sv
// Captures one channel-major SPS frame and replays it row-major over a
// valid/ready handshake through a 2-entry output stage.
module sps_token_reorder_buffer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CHNNLS    = 384,
  parameter int unsigned ROWS      = 8,   // power of two: address uses a shift
  parameter int unsigned FRAME_LEN = CHNNLS * ROWS
) (
  input  logic                 s_clk,
  input  logic                 s_rst_n,
  input  logic                 i_clear,
  input  logic                 i_data_valid,
  input  logic [DATA_W-1:0]    i_fmap,
  input  logic [DATA_W-1:0]    i_patchdata,
  sps_token_reorder_buffer_if.master tok,
  output logic                 o_frame_done,
  output logic                 o_busy,
  output logic                 o_overrun
);

  localparam int unsigned AW = $clog2(FRAME_LEN);
  localparam int unsigned CW = $clog2(CHNNLS);
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned TW = 2 * DATA_W;

  typedef enum logic {ST_FILL, ST_READ} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_rd_ch;
  logic [RW-1:0]   r_rd_row;
  logic            r_issue_done;
  logic            r_frame_done;
  logic            r_overrun;

  logic [TW-1:0]   r_mem [FRAME_LEN];
  logic [TW-1:0]   r_rdata;
  logic            r_pend;
  logic            r_pend_last;
  logic            r_pend_fin;

  logic [TW-1:0]   r_q_data [2];
  logic            r_q_last [2];
  logic            r_q_fin  [2];
  logic [1:0]      r_cnt;
  logic            r_vld;

  logic            w_wr_en;
  logic            w_pop;
  logic [2:0]      w_used;
  logic            w_issue;
  logic            w_final;
  logic            w_ch_last;
  logic            w_row_last;
  logic [AW-1:0]   w_rd_addr;
  logic [1:0]      w_cnt_nxt;

  // Read issue: only when the output stage plus the in-flight read leave a free slot
  always_comb begin
    w_wr_en    = (r_state == ST_FILL) && i_data_valid && !i_clear;
    w_pop      = r_vld && tok.i_token_ready;
    w_used     = {1'b0, r_cnt} + {2'b00, r_pend} - {2'b00, w_pop};
    w_issue    = (r_state == ST_READ) && !r_issue_done && (w_used < 3'd2);
    w_final    = w_pop && r_q_fin[0];
    w_ch_last  = (r_rd_ch == CW'(CHNNLS - 1));
    w_row_last = (r_rd_row == RW'(ROWS - 1));
    w_rd_addr  = (AW'(r_rd_ch) << RW) + AW'(r_rd_row);
    w_cnt_nxt  = r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
  end

  // Frame RAM: write in FILL, synchronous read in READ (never both at once)
  always_ff @(posedge s_clk) begin
    if (w_wr_en)
      r_mem[r_wr_ptr] <= {i_patchdata, i_fmap};
    if (w_issue)
      r_rdata <= r_mem[w_rd_addr];
  end

  // FILL/READ control, read counters and status flags
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state      <= ST_FILL;
      r_wr_ptr     <= '0;
      r_rd_ch      <= '0;
      r_rd_row     <= '0;
      r_issue_done <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_last  <= 1'b0;
      r_pend_fin   <= 1'b0;
    end else if (i_clear) begin
      r_state      <= ST_FILL;
      r_wr_ptr     <= '0;
      r_rd_ch      <= '0;
      r_rd_row     <= '0;
      r_issue_done <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_last  <= 1'b0;
      r_pend_fin   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_pend       <= w_issue;
      r_pend_last  <= w_ch_last;
      r_pend_fin   <= w_ch_last && w_row_last;
      case (r_state)
        ST_FILL: begin
          if (i_data_valid) begin
            if (r_wr_ptr == AW'(FRAME_LEN - 1)) begin
              r_wr_ptr <= '0;
              r_state  <= ST_READ;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end
        end
        ST_READ: begin
          if (i_data_valid)
            r_overrun <= 1'b1;
          if (w_issue) begin
            if (w_ch_last) begin
              r_rd_ch <= '0;
              if (w_row_last) begin
                r_rd_row     <= '0;
                r_issue_done <= 1'b1;
              end else begin
                r_rd_row <= r_rd_row + 1'b1;
              end
            end else begin
              r_rd_ch <= r_rd_ch + 1'b1;
            end
          end
          if (w_final) begin
            r_state      <= ST_FILL;
            r_frame_done <= 1'b1;
            r_issue_done <= 1'b0;
            r_rd_ch      <= '0;
            r_rd_row     <= '0;
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  // Two-entry output stage; head entry drives the token outputs directly
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_cnt       <= '0;
      r_vld       <= 1'b0;
      r_q_data[0] <= '0;
      r_q_data[1] <= '0;
      r_q_last[0] <= 1'b0;
      r_q_last[1] <= 1'b0;
      r_q_fin[0]  <= 1'b0;
      r_q_fin[1]  <= 1'b0;
    end else if (i_clear) begin
      r_cnt       <= '0;
      r_vld       <= 1'b0;
      r_q_data[0] <= '0;
      r_q_data[1] <= '0;
      r_q_last[0] <= 1'b0;
      r_q_last[1] <= 1'b0;
      r_q_fin[0]  <= 1'b0;
      r_q_fin[1]  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_vld <= (w_cnt_nxt != 2'd0);
      // Push lands in the first slot not occupied after this cycle's pop
      if (r_pend && w_pop) begin
        if (r_cnt == 2'd1) begin
          r_q_data[0] <= r_rdata;
          r_q_last[0] <= r_pend_last;
          r_q_fin[0]  <= r_pend_fin;
        end else begin
          r_q_data[0] <= r_q_data[1];
          r_q_last[0] <= r_q_last[1];
          r_q_fin[0]  <= r_q_fin[1];
          r_q_data[1] <= r_rdata;
          r_q_last[1] <= r_pend_last;
          r_q_fin[1]  <= r_pend_fin;
        end
      end else if (r_pend) begin
        if (r_cnt == 2'd0) begin
          r_q_data[0] <= r_rdata;
          r_q_last[0] <= r_pend_last;
          r_q_fin[0]  <= r_pend_fin;
        end else begin
          r_q_data[1] <= r_rdata;
          r_q_last[1] <= r_pend_last;
          r_q_fin[1]  <= r_pend_fin;
        end
      end else if (w_pop) begin
        r_q_data[0] <= r_q_data[1];
        r_q_last[0] <= r_q_last[1];
        r_q_fin[0]  <= r_q_fin[1];
      end
    end
  end

  assign tok.o_token_valid = r_vld;
  assign tok.o_token_data  = r_q_data[0];
  assign tok.o_token_last  = r_q_last[0];
  assign o_frame_done      = r_frame_done;
  assign o_busy            = (r_state == ST_READ);
  assign o_overrun         = r_overrun;

endmodule

// File: doc/sps_token_reorder_buffer.md
Name: sps_token_reorder_buffer

Overview:
- Sits directly downstream of the SPS eyeriss top. It captures one complete SPS output frame: FRAME_LEN beats of {patchdata, fmap}, with no backpressure from the source.
- The frame arrives channel-major (ch outer, row inner). The block replays it row-major (row outer, ch inner) so the attention part receives all channels of one row contiguously.
- The output side uses a valid/ready handshake into the attention part.

Parameters:
DATA_W, 32, width of each of fmap and patchdata (equals PATCH_EMBED_WIDTH)
CHNNLS, 384, feature channels per frame (FINAL_FMAPS_CHNNLS)
ROWS, 8, rows per channel
FRAME_LEN, CHNNLS*ROWS = 3072, beats per frame; RAM depth

Ports:
s_clk  in  1  clock
s_rst_n  in  1  asynchronous active-low reset
i_clear  in  1  synchronous abort: return to FILL, clear pointers and flags
i_data_valid  in  1  input beat strobe; source cannot be stalled
i_fmap  in  DATA_W  fmap word
i_patchdata  in  DATA_W  patch-embed word
o_token_valid  out  1  output beat valid
o_token_data  out  2*DATA_W  {patchdata, fmap}
o_token_last  out  1  marks the last channel (ch = CHNNLS-1) of a row
i_token_ready  in  1  consumer ready
o_frame_done  out  1  one-cycle pulse after the final output handshake
o_busy  out  1  high in READ
o_overrun  out  1  sticky; an input beat arrived outside FILL

Behaviour:
- Reset (s_rst_n=0, asynchronous) or i_clear:
  - State goes to FILL; wr_ptr=0; rd_row=0; rd_ch=0.
  - All outputs go to 0, including o_token_data and o_overrun.
  - i_clear takes priority over every other event in that cycle.
- Storage: simple dual-port RAM, FRAME_LEN x 2*DATA_W, synchronous read with 1-cycle latency.
- FILL state:
  - Each i_data_valid writes {i_patchdata, i_fmap} at wr_ptr, then wr_ptr increments.
  - The write at wr_ptr = FRAME_LEN-1 moves the state to READ on the next cycle and resets wr_ptr to 0.
- READ state:
  - Read address = rd_ch*ROWS + rd_row. Use shift/add, no multiplier.
  - Counter order: rd_ch increments first; on wrap (CHNNLS-1 → 0), rd_row increments.
  - A read is issued when the output stage has space. Use a 2-entry skid/output stage so the consumer can accept one beat per cycle with no bubbles.
  - o_token_data, o_token_last and o_token_valid hold stable while valid=1 and ready=0.
  - First o_token_valid rises exactly 2 cycles after entering READ.
  - o_token_last = 1 when the presented beat has ch = CHNNLS-1.
  - When the handshake of the beat (row ROWS-1, ch CHNNLS-1) completes:
    - o_frame_done pulses for 1 cycle the following cycle.
    - State returns to FILL.
    - Read counters return to 0.
    - o_token_valid is 0 that cycle.
- Overrun:
  - i_data_valid in READ, including the cycle of the final handshake, is dropped: no RAM write, no pointer change.
  - That event sets o_overrun, which stays set until reset or i_clear.
- o_busy = 1 exactly while state == READ.
- No output is produced while in FILL. o_token_valid = 0 throughout FILL.
- Back-to-back frames: input may begin on the cycle after o_frame_done is asserted. Beats arriving in that cycle are accepted.
- Widths:
  - wr_ptr: clog2(FRAME_LEN) bits.
  - rd_ch: clog2(CHNNLS) bits.
  - rd_row: clog2(ROWS) bits.
  - Address arithmetic is done in clog2(FRAME_LEN) bits, with no truncation before the add.

Test Plan:
1. Fill with fmap = address, patchdata = ~address, ready held 1. Expected: 3072 output beats with no gaps; beat k carries address (k%384)*8 + k/384; o_token_last on k = 383, 767, …, 3071; one o_frame_done pulse; o_overrun = 0.
2. Random ready (50%) during READ. Expected: beat sequence identical to scenario 1; data held stable under stall; total handshakes = 3072.
3. Inject i_data_valid at output beat 100 of READ. Expected: o_overrun = 1 and stays set; the next frame fills from address 0, with the dropped beat not written.
4. Two frames back-to-back, second frame starting the cycle after o_frame_done. Expected: second replay correct, first word = frame2 address 0.
5. i_clear asserted after 1000 input beats. Expected: all outputs 0 the next cycle; a new full frame fills and replays correctly with no stale data.
6. Drop s_rst_n asynchronously mid-READ (between clock edges). Expected: outputs go to 0 immediately; after release, state is FILL and a full frame replays correctly.
